// File: rtl/clint.sv
// Purpose     : core-local interruptor with 64-bit mtime, mtimecmp and msip on the dmem bus.
// Latency     : read data and write_ready are registered, one cycle after the accepting edge.
// Backpressure: none; every read and write is accepted on the edge where it is presented.
module clint #(
   parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
   parameter int unsigned TICK_DIV  = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] address,
   input  logic        read_enable,
   output logic [31:0] read_data,
   output logic        read_valid,
   input  logic [31:0] write_data,
   input  logic        write_enable,
   input  logic [3:0]  write_wstrb,
   output logic        write_ready,
   output logic        timer_int,
   output logic        soft_int
);

   // Word offsets (byte offset >> 2) of the mapped registers inside the 64 KiB window.
   localparam logic [13:0] OFS_MSIP    = 14'h0000;  // 0x0000
   localparam logic [13:0] OFS_CMP_LO  = 14'h1000;  // 0x4000
   localparam logic [13:0] OFS_CMP_HI  = 14'h1001;  // 0x4004
   localparam logic [13:0] OFS_TIME_LO = 14'h2FFE;  // 0xBFF8
   localparam logic [13:0] OFS_TIME_HI = 14'h2FFF;  // 0xBFFC

   // Terminal prescaler count; TICK_DIV=1 gives 0, so every cycle is a tick.
   localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);

   // One-hot register select produced by the address decoder.
   typedef struct packed {
      logic msip;
      logic cmp_lo;
      logic cmp_hi;
      logic time_lo;
      logic time_hi;
   } reg_sel_t;

   // Architectural state.
   logic [63:0] mtime;
   logic [63:0] mtimecmp;
   logic        msip;
   logic [15:0] presc;

   // Next-state values; timer_int is computed from these so it tracks post-edge state.
   logic [63:0] mtime_nxt;
   logic [63:0] mtimecmp_nxt;
   logic [15:0] presc_nxt;
   logic        presc_wrap;

   // Decode results.
   logic        win_hit;
   reg_sel_t    sel;
   reg_sel_t    rd_sel;
   reg_sel_t    wr_sel;
   logic [31:0] rd_mux;

   // Byte-lane address bits carry no meaning on this word-wide register file.
   logic        unused_addr_lsb;
   assign unused_addr_lsb = ^address[1:0];

   // Merge the byte lanes enabled in strb from new_val over old_val.
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
      logic [31:0] r;
      r = old_val;
      for (int i = 0; i < 4; i++) begin
         if (strb[i]) r[8*i +: 8] = new_val[8*i +: 8];
      end
      return r;
   endfunction

   // Address decode: window match on the upper half, then exact word match inside it.
   always_comb begin
      win_hit = (address[31:16] == BASE_ADDR[31:16]);
      sel     = '0;
      if (win_hit) begin
         case (address[15:2])
            OFS_MSIP:    sel.msip    = 1'b1;
            OFS_CMP_LO:  sel.cmp_lo  = 1'b1;
            OFS_CMP_HI:  sel.cmp_hi  = 1'b1;
            OFS_TIME_LO: sel.time_lo = 1'b1;
            OFS_TIME_HI: sel.time_hi = 1'b1;
            default:     sel         = '0;
         endcase
      end
   end

   // Qualify the shared decode with each request; reads and writes may coexist.
   assign rd_sel = read_enable  ? sel : '0;
   assign wr_sel = write_enable ? sel : '0;

   // Read mux over pre-edge state; unmapped addresses return zero.
   always_comb begin
      rd_mux = '0;
      if (rd_sel.msip)    rd_mux = {31'b0, msip};
      if (rd_sel.cmp_lo)  rd_mux = mtimecmp[31:0];
      if (rd_sel.cmp_hi)  rd_mux = mtimecmp[63:32];
      if (rd_sel.time_lo) rd_mux = mtime[31:0];
      if (rd_sel.time_hi) rd_mux = mtime[63:32];
   end

   // Prescaler runs freely; a software write to mtime does not disturb it.
   always_comb begin
      presc_wrap = (presc == PRESC_MAX);
      presc_nxt  = presc_wrap ? 16'd0 : presc + 16'd1;
   end

   // mtime: a software write replaces that edge's increment; the other half is kept.
   always_comb begin
      mtime_nxt = mtime;
      if (wr_sel.time_lo || wr_sel.time_hi) begin
         mtime_nxt[31:0]  = wr_sel.time_lo ? merge_bytes(mtime[31:0], write_data, write_wstrb)
                                           : mtime[31:0];
         mtime_nxt[63:32] = wr_sel.time_hi ? merge_bytes(mtime[63:32], write_data, write_wstrb)
                                           : mtime[63:32];
      end else if (presc_wrap) begin
         mtime_nxt = mtime + 64'd1;
      end
   end

   // mtimecmp: byte-merged writes to either half.
   always_comb begin
      mtimecmp_nxt = mtimecmp;
      if (wr_sel.cmp_lo) mtimecmp_nxt[31:0]  = merge_bytes(mtimecmp[31:0], write_data, write_wstrb);
      if (wr_sel.cmp_hi) mtimecmp_nxt[63:32] = merge_bytes(mtimecmp[63:32], write_data, write_wstrb);
   end

   // Counter, compare and prescaler state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mtime    <= 64'd0;
         mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
         presc    <= 16'd0;
      end else begin
         mtime    <= mtime_nxt;
         mtimecmp <= mtimecmp_nxt;
         presc    <= presc_nxt;
      end
   end

   // Software interrupt bit; only byte lane 0 carries it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         msip <= 1'b0;
      end else if (wr_sel.msip && write_wstrb[0]) begin
         msip <= write_data[0];
      end
   end

   // Timer interrupt level from post-update values, so it appears with the matching mtime.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         timer_int <= 1'b0;
      end else begin
         timer_int <= (mtime_nxt >= mtimecmp_nxt);
      end
   end

   // Bus responses: single-cycle pulses; read_data holds between reads.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         read_data   <= 32'd0;
         read_valid  <= 1'b0;
         write_ready <= 1'b0;
      end else begin
         read_valid  <= read_enable;
         write_ready <= write_enable;
         if (read_enable) read_data <= rd_mux;
      end
   end

   assign soft_int = msip;

endmodule

// File: tb/tb_clint.sv
// Purpose     : directed, table-driven bench for clint with TICK_DIV=4 and TICK_DIV=1 instances.
// Latency     : samples on negedges; a bus access completes one negedge after it is driven.
// Backpressure: none expected from the design; all waits are fixed clock counts.
module tb_clint;

   logic        clk;
   logic        reset;
   logic        sel;          // 0 selects the TICK_DIV=4 instance, 1 the TICK_DIV=1 instance
   logic [31:0] address;
   logic        read_enable;
   logic [31:0] write_data;
   logic        write_enable;
   logic [3:0]  write_wstrb;

   logic [31:0] rd_data_a, rd_data_b;
   logic        rd_vld_a, rd_vld_b, wr_rdy_a, wr_rdy_b;
   logic        tmr_a, tmr_b, sft_a, sft_b;
   logic        re_a, re_b, we_a, we_b;

   logic [31:0] rdata;
   logic        rvalid, wready, tint, sint;

   int n_tests = 0;
   int n_fail  = 0;

   assign re_a = read_enable  & ~sel;
   assign re_b = read_enable  &  sel;
   assign we_a = write_enable & ~sel;
   assign we_b = write_enable &  sel;

   assign rdata  = sel ? rd_data_b : rd_data_a;
   assign rvalid = sel ? rd_vld_b  : rd_vld_a;
   assign wready = sel ? wr_rdy_b  : wr_rdy_a;
   assign tint   = sel ? tmr_b     : tmr_a;
   assign sint   = sel ? sft_b     : sft_a;

   clint #(.BASE_ADDR(32'h0200_0000), .TICK_DIV(4)) u_dut (
      .clk(clk), .reset(reset), .address(address),
      .read_enable(re_a), .read_data(rd_data_a), .read_valid(rd_vld_a),
      .write_data(write_data), .write_enable(we_a), .write_wstrb(write_wstrb),
      .write_ready(wr_rdy_a), .timer_int(tmr_a), .soft_int(sft_a)
   );

   clint #(.BASE_ADDR(32'h0200_0000), .TICK_DIV(1)) u_dut1 (
      .clk(clk), .reset(reset), .address(address),
      .read_enable(re_b), .read_data(rd_data_b), .read_valid(rd_vld_b),
      .write_data(write_data), .write_enable(we_b), .write_wstrb(write_wstrb),
      .write_ready(wr_rdy_b), .timer_int(tmr_b), .soft_int(sft_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic v);
      @(negedge clk);
      address     = a;
      read_enable = 1'b1;
      @(negedge clk);
      d           = rdata;
      v           = rvalid;
      read_enable = 1'b0;
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] strb, output logic rdy);
      @(negedge clk);
      address      = a;
      write_data   = wd;
      write_wstrb  = strb;
      write_enable = 1'b1;
      @(negedge clk);
      rdy          = wready;
      write_enable = 1'b0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset        = 1'b0;
      read_enable  = 1'b0;
      write_enable = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
   endtask

   typedef struct {
      bit          is_wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [31:0] exp_rd;
      logic        exp_soft;
      string       name;
   } vec_t;

   vec_t vt[$];

   task automatic add_vec(input bit w, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] s, input logic [31:0] e, input logic so,
                          input string n);
      vec_t x;
      x.is_wr = w; x.addr = a; x.wdata = wd; x.strb = s;
      x.exp_rd = e; x.exp_soft = so; x.name = n;
      vt.push_back(x);
   endtask

   logic [31:0] d;
   logic        v, r;

   initial begin
      reset = 1'b0; sel = 1'b0; address = '0; read_enable = 1'b0;
      write_data = '0; write_enable = 1'b0; write_wstrb = '0;

      // Register-map vectors, applied to the TICK_DIV=4 instance after a fresh reset.
      add_vec(0, 32'h0200_4000, 0, 0, 32'hFFFF_FFFF, 0, "tbl cmp_lo reset");
      add_vec(0, 32'h0200_4004, 0, 0, 32'hFFFF_FFFF, 0, "tbl cmp_hi reset");
      add_vec(0, 32'h0200_0000, 0, 0, 32'h0000_0000, 0, "tbl msip reset");
      add_vec(1, 32'h0200_4000, 32'h1234_5678, 4'b0011, 0, 0, "tbl wr cmp_lo lanes01");
      add_vec(0, 32'h0200_4000, 0, 0, 32'hFFFF_5678, 0, "tbl cmp_lo merged");
      add_vec(1, 32'h0200_4004, 32'hAABB_CCDD, 4'b1100, 0, 0, "tbl wr cmp_hi lanes23");
      add_vec(0, 32'h0200_4004, 0, 0, 32'hAABB_FFFF, 0, "tbl cmp_hi merged");
      add_vec(0, 32'h0300_4000, 0, 0, 32'h0000_0000, 0, "tbl wrong base read");
      add_vec(1, 32'h0300_0000, 32'h1, 4'b0001, 0, 0, "tbl wrong base write");
      add_vec(0, 32'h0200_0000, 0, 0, 32'h0000_0000, 0, "tbl msip untouched");
      add_vec(1, 32'h0200_0000, 32'hFFFF_FFFF, 4'b1111, 0, 1, "tbl msip set");
      add_vec(0, 32'h0200_0000, 0, 0, 32'h0000_0001, 1, "tbl msip bit0 only");
      add_vec(1, 32'h0200_0000, 32'h0, 4'b0000, 0, 1, "tbl msip wstrb0");
      add_vec(0, 32'h0200_0000, 0, 0, 32'h0000_0001, 1, "tbl msip kept");
      add_vec(1, 32'h0200_0000, 32'h0, 4'b0001, 0, 0, "tbl msip clear");
      add_vec(0, 32'h0200_0000, 0, 0, 32'h0000_0000, 0, "tbl msip cleared");
      add_vec(0, 32'h0200_1000, 0, 0, 32'h0000_0000, 0, "tbl hole 0x1000");
      add_vec(0, 32'h0200_4008, 0, 0, 32'h0000_0000, 0, "tbl hole 0x4008");
      add_vec(0, 32'h0200_BFFC, 0, 0, 32'h0000_0000, 0, "tbl mtime_hi small");
      add_vec(1, 32'h0200_4003, 32'h0, 4'b1111, 0, 0, "tbl wr cmp_lo addr lsb");
      add_vec(0, 32'h0200_4000, 0, 0, 32'h0000_0000, 0, "tbl cmp_lo lsb ignored");

      // 1: outputs held at zero during reset, then mtimecmp reset value.
      repeat (3) @(negedge clk);
      check("rst read_data", rd_data_a, 32'h0);
      check1("rst read_valid", rd_vld_a, 1'b0);
      check1("rst write_ready", wr_rdy_a, 1'b0);
      check1("rst timer_int", tmr_a, 1'b0);
      check1("rst soft_int", sft_a, 1'b0);
      check1("rst timer_int div1", tmr_b, 1'b0);
      reset = 1'b1;
      bus_read(32'h0200_4000, d, v);
      check("rst cmp_lo", d, 32'hFFFF_FFFF);
      check1("rst cmp_lo valid", v, 1'b1);
      bus_read(32'h0200_4004, d, v);
      check("rst cmp_hi", d, 32'hFFFF_FFFF);

      // 2: TICK_DIV=4, read mtime after 40 edges -> state after edge 40 = 10.
      apply_reset();
      repeat (40) @(posedge clk);
      bus_read(32'h0200_BFF8, d, v);
      check("div4 mtime_lo", d, 32'd10);
      bus_read(32'h0200_BFFC, d, v);
      check("div4 mtime_hi", d, 32'd0);

      // 5: simultaneous read and write, then unmapped read and read_data hold.
      apply_reset();
      @(negedge clk);
      address = 32'h0200_4000; write_data = 32'h55; write_wstrb = 4'hF;
      write_enable = 1'b1; read_enable = 1'b1;
      @(negedge clk);
      d = rdata; v = rvalid; r = wready;
      write_enable = 1'b0; read_enable = 1'b0;
      check("rw old value", d, 32'hFFFF_FFFF);
      check1("rw read_valid", v, 1'b1);
      check1("rw write_ready", r, 1'b1);
      bus_read(32'h0000_1000, d, v);
      check("unmapped data", d, 32'h0);
      check1("unmapped valid", v, 1'b1);
      bus_read(32'h0200_4000, d, v);
      check("rw new value", d, 32'h0000_0055);
      @(negedge clk);
      check("read_data hold", rdata, 32'h0000_0055);
      check1("read_valid pulse", rvalid, 1'b0);

      // 4: msip byte-lane behaviour and single write_ready pulse.
      bus_write(32'h0200_0000, 32'h1, 4'b0001, r);
      check1("msip set ready", r, 1'b1);
      check1("msip set soft", sint, 1'b1);
      @(negedge clk);
      check1("write_ready pulse", wready, 1'b0);
      bus_write(32'h0200_0000, 32'h0, 4'b0010, r);
      check1("msip lane1 soft", sint, 1'b1);
      bus_write(32'h0200_0000, 32'h0, 4'b0001, r);
      check1("msip clear soft", sint, 1'b0);

      // Table-driven register map vectors.
      apply_reset();
      foreach (vt[i]) begin
         if (vt[i].is_wr) begin
            bus_write(vt[i].addr, vt[i].wdata, vt[i].strb, r);
            check1({vt[i].name, " ready"}, r, 1'b1);
         end else begin
            bus_read(vt[i].addr, d, v);
            check(vt[i].name, d, vt[i].exp_rd);
            check1({vt[i].name, " valid"}, v, 1'b1);
         end
         check1({vt[i].name, " soft"}, sint, vt[i].exp_soft);
      end
      check1("tbl timer_int low", tint, 1'b0);

      // 3: TICK_DIV=1 carry into mtime_hi and exact timer_int rise.
      apply_reset();
      sel = 1'b1;
      bus_write(32'h0200_4004, 32'h1, 4'hF, r);
      bus_write(32'h0200_4000, 32'h0, 4'hF, r);
      check1("div1 timer before", tint, 1'b0);
      bus_write(32'h0200_BFFC, 32'h0, 4'hF, r);
      bus_write(32'h0200_BFF8, 32'hFFFF_FFFF, 4'hF, r);
      check1("div1 timer at FFFFFFFF", tint, 1'b0);
      @(negedge clk);
      check1("div1 timer at carry", tint, 1'b1);
      bus_read(32'h0200_BFFC, d, v);
      check("div1 mtime_hi carry", d, 32'h1);
      bus_read(32'h0200_BFF8, d, v);
      check("div1 mtime_lo", d, 32'h3);
      check1("div1 timer held", tint, 1'b1);
      bus_write(32'h0200_4004, 32'hFFFF_FFFF, 4'hF, r);
      check1("div1 timer cleared", tint, 1'b0);
      sel = 1'b0;

      // 6: reset during a pending read drops read_valid and clears mtime.
      repeat (20) @(negedge clk);
      address = 32'h0200_BFF8;
      read_enable = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      read_enable = 1'b0;
      @(negedge clk);
      check1("mid rst read_valid", rvalid, 1'b0);
      @(negedge clk);
      check1("mid rst no late pulse", rvalid, 1'b0);
      check("mid rst read_data", rdata, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      bus_read(32'h0200_BFF8, d, v);
      check("mid rst mtime_lo", d, 32'h0);
      check1("mid rst new read valid", v, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
